param_mem_loader: RTL and testbench

PARAM_MEM_LOADER -- requirements
Module: param_mem_loader

---
 rtl/param_mem_loader.sv | 106 ++++++++++
 tb/tb_param_mem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_mem_loader.sv
// Streams in_valid/in_data words into a DEPTH x WIDTH memory through an IDLE/LOAD/DONE FSM, with a registered read port.
// Defining MEM_LOADER_CKSUM_EN adds a cksum output: the running XOR of every word written during the current pass.
module param_mem_loader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
`ifdef MEM_LOADER_CKSUM_EN
  ,
  output logic [WIDTH-1:0]  cksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;
  logic              enter_load;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    enter_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        // abort takes priority over a transfer presented on the same cycle
        if (abort) begin
          state_next = IDLE;
        end else if (in_valid) begin
          xfer = 1'b1;
          if (count == LAST_CNT) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  // count saturates at DEPTH by construction: the transfer that reaches DEPTH also leaves LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (enter_load) begin
      ptr   <= '0;
      count <= '0;
    end else if (xfer) begin
      ptr   <= ptr + 1'b1;
      count <= count + 1'b1;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst, and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (xfer && !rst) mem[ptr] <= in_data;
  end

  // A read of the address being written on the same edge returns the old word.
  always_ff @(posedge clk) begin
    if (rst)                           rd_data <= '0;
    else if ({1'b0, rd_addr} < DEPTH_CNT) rd_data <= mem[rd_addr];
    else                               rd_data <= '0;
  end

`ifdef MEM_LOADER_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || enter_load) cksum <= '0;
    else if (xfer)         cksum <= cksum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_param_mem_loader.sv
// Directed bench for param_mem_loader: a default instance plus a DEPTH=4/ADDR_W=3 instance on shared stimulus.
// Read results are checked by a scoreboard queue drained in a separate monitor process.
module tb_param_mem_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid;
  logic [7:0] in_data;
  logic [3:0] rd_addr;
  logic       rd_req = 1'b0;
  logic       rd_pend = 1'b0;

  logic       in_ready, busy, done;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       in_ready_b, busy_b, done_b;
  logic [7:0] rd_data_b;
  logic [3:0] count_b;
`ifdef MEM_LOADER_CKSUM_EN
  logic [7:0] cksum, cksum_b;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  always #5 clk = ~clk;

  param_mem_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .count(count)
`ifdef MEM_LOADER_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  param_mem_loader #(.WIDTH(8), .DEPTH(4), .ADDR_W(3)) u_small (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .rd_addr(rd_addr[2:0]), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .count(count_b)
`ifdef MEM_LOADER_CKSUM_EN
    , .cksum(cksum_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ea, input logic [7:0] eb);
    rd_exp_t e;
    e.a = ea;
    e.b = eb;
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("rd_q_underflow", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.a));
        check("rd_data_small", 32'(rd_data_b), 32'(e.b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = 8'h77; rd_addr = '0;
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_count_small", 32'(count_b), 32'd0);

    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_in_ready", 32'(in_ready), 32'd1);
    check("load_count0", 32'(count), 32'd0);

    // full load 0x00..0x0F; the small instance fills after 4 words
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      check("full_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    check("full_count16", 32'(count), 32'd16);
    check("small_done", 32'(done_b), 32'd1);
    check("small_count4", 32'(count_b), 32'd4);
    rd(4'd5, 8'h05, 8'h00);
    rd(4'd3, 8'h03, 8'h03);
    rd(4'd15, 8'h0F, 8'h00);
    rd(4'd0, 8'h00, 8'h00);
    tick();
    check("done_hold", 32'(done), 32'd1);

    // restart, start held through LOAD, stall, then read-before-write and abort
    start = 1'b1;
    tick();
    repeat (3) tick();
    start = 1'b0;
    check("stall_count", 32'(count), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h20;
    rd(4'd0, 8'h00, 8'h00);
    in_data = 8'h21;
    tick();
    in_data = 8'h22;
    tick();
    check("pre_abort_count", 32'(count), 32'd3);
    in_data = 8'hAA;
    abort   = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_count", 32'(count), 32'd3);
    check("abort_count_small", 32'(count_b), 32'd3);
    rd(4'd3, 8'h03, 8'h03);
    rd(4'd0, 8'h20, 8'h20);
    rd(4'd2, 8'h22, 8'h22);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_count", 32'(count), 32'd3);
    check("idle_abort_busy", 32'(busy), 32'd0);

    // reset mid-LOAD after 5 transfers, with a word in flight
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h30 + i);
      tick();
    end
    check("mid_count5", 32'(count), 32'd5);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_small_done", 32'(done_b), 32'd1);
    check("mid_small_count", 32'(count_b), 32'd4);
    in_data = 8'hBB;
    rst     = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_small_done", 32'(done_b), 32'd0);
    check("mid_rst_small_count", 32'(count_b), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(4'(i), 8'(8'h30 + i), (i < 4) ? 8'(8'h30 + i) : 8'h00);
    end
    rd(4'd5, 8'h05, 8'h00);

`ifdef MEM_LOADER_CKSUM_EN
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h04; tick();
    in_data = 8'h08; tick();
    in_valid = 1'b0;
    check("cksum_small", 32'(cksum_b), 32'h0F);
    check("cksum_main", 32'(cksum), 32'h0F);
    check("cksum_small_done", 32'(done_b), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cksum_small_restart", 32'(cksum_b), 32'h00);
    check("cksum_main_in_load", 32'(cksum), 32'h0F);
`endif

    repeat (2) tick();
    check("rd_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
